// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
//
// Writer side of the processor's instruction memory. The block receives a
// framed byte stream, assembles big-endian 32-bit instruction words, writes
// them into instruction memory, and holds the processor in reset until a
// complete frame has been loaded and its checksum has been verified.
//
// Frame layout on the byte stream:
//   LEN_HI, LEN_LO   word count N, big-endian
//   4*N data bytes   each instruction word sent MSB first
//   CHK              XOR of every preceding frame byte, length bytes included
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   start        begin frame reception (honoured only in IDLE, DONE, ERR)
//   byte_valid   byte_data carries a byte this cycle
//   byte_data    stream byte
//   byte_ready   loader takes a byte this cycle (transfer = valid & ready)
//   wea          instruction memory write enable, one-cycle pulse per word
//   addra        instruction memory word address
//   dina         instruction word to write
//   cpu_reset    holds the processor in reset while high
//   done         frame loaded and checksum good
//   error        frame rejected (oversize or checksum mismatch)
//   words_loaded words written in the current or last frame
// -----------------------------------------------------------------------------
module imem_program_loader #(
    parameter int size    = 32,   // instruction word / address width
    parameter int MemSize = 512,  // memory depth in words, largest legal N
    parameter int CntW    = 16    // width of word counters
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            wea,
    output logic [size-1:0] addra,
    output logic [size-1:0] dina,
    output logic            cpu_reset,
    output logic            done,
    output logic            error,
    output logic [CntW-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] len_q;       // word count N from the two length bytes
    logic [7:0]  chk_acc;     // running XOR of accepted frame bytes
    logic [23:0] asm_q;       // first three bytes of the word being assembled
    logic [1:0]  byte_idx;    // position of the next data byte within its word

    logic        xfer;        // a byte is taken this cycle
    logic        restart;     // start honoured: clear per-frame bookkeeping
    logic        word_done;   // this transfer completes an instruction word
    logic        last_word;   // the word being completed is word N-1
    logic [15:0] len_full;    // length as it will be once LEN_LO is taken

    assign xfer      = byte_valid & byte_ready;
    assign len_full  = {len_q[15:8], byte_data};
    assign last_word = (int'(words_loaded) + 1) == int'(len_q);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next = state;
        byte_ready = 1'b0;
        restart    = 1'b0;
        word_done  = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_LEN_HI;
                    restart    = 1'b1;
                end
            end

            S_LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    // Oversize frames are refused before any write, which is
                    // what keeps addra from ever wrapping.
                    if (int'(len_full) > MemSize) begin
                        state_next = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_next = S_CHK;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end

            S_DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && byte_idx == 2'd3) begin
                    word_done = 1'b1;
                    if (last_word) begin
                        state_next = S_CHK;
                    end
                end
            end

            S_CHK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = (byte_data == chk_acc) ? S_DONE : S_ERR;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: length capture, checksum, word assembly and memory writes
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state elements are updated with non-blocking assignments so
        // every register samples pre-edge values regardless of statement order.
        if (reset) begin
            len_q        <= '0;
            chk_acc      <= '0;
            asm_q        <= '0;
            byte_idx     <= '0;
            wea          <= 1'b0;
            addra        <= '0;
            dina         <= '0;
            words_loaded <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // Status flags follow the state being entered, so they are
            // registered and glitch-free; cpu_reset rises again on the same
            // edge that leaves DONE for a new frame.
            done      <= (state_next == S_DONE);
            error     <= (state_next == S_ERR);
            cpu_reset <= (state_next != S_DONE);

            // Write enable is a single-cycle pulse unless a word completes.
            wea <= 1'b0;

            if (restart) begin
                chk_acc      <= '0;
                words_loaded <= '0;
                byte_idx     <= '0;
            end

            // The CHK byte itself is compared, not accumulated.
            if (xfer && state != S_CHK) begin
                chk_acc <= chk_acc ^ byte_data;
            end

            if (xfer && state == S_LEN_HI) begin
                len_q[15:8] <= byte_data;
            end

            if (xfer && state == S_LEN_LO) begin
                len_q[7:0] <= byte_data;
            end

            if (xfer && state == S_DATA) begin
                asm_q    <= {asm_q[15:0], byte_data};
                byte_idx <= byte_idx + 2'd1;
            end

            // The word index before increment is this word's address; the
            // count moves on the same edge that raises wea.
            if (word_done) begin
                wea          <= 1'b1;
                addra        <= size'(words_loaded);
                dina         <= size'({asm_q, byte_data});
                words_loaded <= words_loaded + CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_program_loader
//
// Drives framed byte streams (directed and random) into imem_program_loader,
// logs every instruction memory write, and compares writes and final status
// against expectations computed from the frame bytes themselves.
// -----------------------------------------------------------------------------
module tb_imem_program_loader;

    localparam int SIZE     = 32;
    localparam int MEM_SIZE = 512;
    localparam int CNT_W    = 16;

    typedef logic [7:0] bytes_t[$];

    logic             clk;
    logic             reset;
    logic             start;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             wea;
    logic [SIZE-1:0]  addra;
    logic [SIZE-1:0]  dina;
    logic             cpu_reset;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] words_loaded;

    imem_program_loader #(
        .size    (SIZE),
        .MemSize (MEM_SIZE),
        .CntW    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .wea          (wea),
        .addra        (addra),
        .dina         (dina),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Write log, captured away from the rising edge
    int          cyc = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wea === 1'b1) begin
            got_addr.push_back(addra);
            got_data.push_back(dina);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer the first nsend bytes of q, optionally with random idle gaps
    // (carrying junk data and stray start pulses that must be ignored).
    task automatic send_bytes(input bytes_t q, input int nsend, input bit stall);
        bit accepted;
        for (int i = 0; i < nsend; i++) begin
            if (stall) begin
                repeat ($urandom_range(0, 3)) begin
                    byte_valid = 1'b0;
                    byte_data  = 8'($urandom);
                    start      = ($urandom_range(0, 4) == 0);
                    tick();
                end
            end
            start      = 1'b0;
            byte_valid = 1'b1;
            byte_data  = q[i];
            accepted   = 1'b0;
            for (int c = 0; c < 50 && !accepted; c++) begin
                accepted = byte_ready;
                tick();
            end
            if (!accepted) check("byte_accept_timeout", 0, 1);
        end
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    function automatic bytes_t make_frame(input int n, input bit good);
        bytes_t     q;
        logic [7:0] x;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        if (n <= MEM_SIZE) begin
            for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
            x = 8'h00;
            foreach (q[i]) x ^= q[i];
            q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
        end
        return q;
    endfunction

    // Run one frame and compare against expectations derived from its bytes.
    task automatic run_frame(input string name, input bytes_t q, input bit stall, input bit check_gap);
        int          n;
        bit          over;
        bit          good;
        int          nsend;
        logic [7:0]  x;
        logic [31:0] w;
        int          exp_writes;

        got_addr.delete();
        got_data.delete();
        got_cyc.delete();

        pulse_start();
        check({name, "/start_cpu_reset"}, cpu_reset, 1);
        check({name, "/start_ready"}, byte_ready, 1);
        check({name, "/start_done"}, done, 0);
        check({name, "/start_error"}, error, 0);

        n     = (int'(q[0]) << 8) | int'(q[1]);
        over  = n > MEM_SIZE;
        nsend = over ? 2 : 4 * n + 3;
        good  = 1'b0;
        if (!over) begin
            x = 8'h00;
            for (int i = 0; i < 4 * n + 2; i++) x ^= q[i];
            good = (q[4 * n + 2] == x);
        end
        exp_writes = over ? 0 : n;

        send_bytes(q, nsend, stall);

        // Valid bytes after the frame must be ignored.
        byte_valid = 1'b1;
        repeat (3) begin
            byte_data = 8'($urandom);
            tick();
        end
        byte_valid = 1'b0;
        tick();

        check({name, "/done"}, done, (!over && good));
        check({name, "/error"}, error, !(!over && good));
        check({name, "/cpu_reset"}, cpu_reset, !(!over && good));
        check({name, "/byte_ready_end"}, byte_ready, 0);
        check({name, "/words_loaded"}, words_loaded, exp_writes);
        check({name, "/write_count"}, got_addr.size(), exp_writes);
        for (int i = 0; i < exp_writes && i < got_addr.size(); i++) begin
            w = {q[2 + 4 * i], q[3 + 4 * i], q[4 + 4 * i], q[5 + 4 * i]};
            check({name, $sformatf("/addr%0d", i)}, got_addr[i], i);
            check({name, $sformatf("/data%0d", i)}, got_data[i], w);
        end
        if (check_gap) begin
            for (int i = 1; i < got_cyc.size(); i++) begin
                check({name, $sformatf("/gap%0d", i)}, got_cyc[i] - got_cyc[i - 1], 4);
            end
        end
    endtask

    bytes_t normal_frame;
    bytes_t bad_frame;
    bytes_t over_frame;
    bytes_t zero_frame;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        normal_frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                         8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02};
        bad_frame    = normal_frame;
        bad_frame[10] = 8'h03;
        over_frame   = '{8'h02, 8'h01};
        zero_frame   = '{8'h00, 8'h00, 8'h00};

        tick();
        tick();
        check("rst/wea", wea, 0);
        check("rst/addra", addra, 0);
        check("rst/dina", dina, 0);
        check("rst/cpu_reset", cpu_reset, 1);
        check("rst/done", done, 0);
        check("rst/error", error, 0);
        check("rst/byte_ready", byte_ready, 0);
        check("rst/words_loaded", words_loaded, 0);
        reset = 1'b0;
        tick();

        // Bytes offered in IDLE are ignored and must not disturb the
        // checksum of the zero-length frame that follows.
        byte_valid = 1'b1;
        repeat (3) begin
            byte_data = 8'($urandom_range(1, 255));
            tick();
            check("idle/byte_ready", byte_ready, 0);
        end
        byte_valid = 1'b0;

        run_frame("zero", zero_frame, 1'b0, 1'b0);
        run_frame("normal", normal_frame, 1'b0, 1'b1);
        run_frame("bad_chk", bad_frame, 1'b0, 1'b0);
        run_frame("oversize", over_frame, 1'b0, 1'b0);
        run_frame("stall", normal_frame, 1'b1, 1'b0);
        run_frame("b2b", normal_frame, 1'b0, 1'b1);
        run_frame("max_len", make_frame(MEM_SIZE, 1'b1), 1'b0, 1'b1);

        // Reset after the 6th data byte, then a clean reload.
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        pulse_start();
        send_bytes(normal_frame, 8, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst/wea", wea, 0);
        check("midrst/addra", addra, 0);
        check("midrst/cpu_reset", cpu_reset, 1);
        check("midrst/done", done, 0);
        check("midrst/byte_ready", byte_ready, 0);
        check("midrst/words_loaded", words_loaded, 0);
        check("midrst/writes_before", got_addr.size(), 1);
        if (got_addr.size() > 0) check("midrst/data0", got_data[0], 32'h12345678);
        tick();
        run_frame("after_rst", normal_frame, 1'b0, 1'b0);

        // Random frames: mixed lengths, checksum faults, stalls, oversize.
        for (int k = 0; k < 20; k++) begin
            int n;
            n = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) n = $urandom_range(MEM_SIZE + 1, 65535);
            run_frame($sformatf("rand%0d", k), make_frame(n, $urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the processor's instruction memory. The processor only reads instruction memory, so this block fills it.
- Receives a framed byte stream (length, big-endian instruction words, checksum) and assembles 32-bit words.
- Drives the instruction memory write port (wea/addra/dina) and holds the processor in reset until a frame is loaded and verified.

Parameters:
- size, 32, instruction word / address width.
- MemSize, 512, instruction memory depth in words; maximum legal word count.
- CntW, 16, width of the word-count field and counters.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin frame reception; sampled in IDLE, DONE, ERR.
- byte_valid  input  1  byte_data valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle; transfer = byte_valid & byte_ready.
- wea  output  1  instruction memory write enable, one-cycle pulse per word.
- addra  output  size  instruction memory word address.
- dina  output  size  instruction word to write.
- cpu_reset  output  1  hold processor (PC) in reset while high.
- done  output  1  frame loaded and checksum good.
- error  output  1  frame rejected (oversize or checksum mismatch).
- words_loaded  output  CntW  words written in current/last frame.

Behaviour:
- Reset values: wea=0, addra=0, dina=0, cpu_reset=1, done=0, error=0, byte_ready=0, words_loaded=0, state=IDLE, checksum accumulator=0.
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), 4*N data bytes (each word MSB first), CHK byte.
- Checksum rule: CHK must equal the XOR of all preceding frame bytes, including both length bytes.
- States:
  - IDLE: byte_ready=0. On start go to LEN_HI; clear checksum, words_loaded and byte index; set cpu_reset=1, done=0, error=0.
  - LEN_HI: byte_ready=1. On transfer, latch N[15:8] and go to LEN_LO.
  - LEN_LO: byte_ready=1. On transfer, latch N[7:0]. If N > MemSize go to ERR. Else if N==0 go to CHK. Else go to DATA.
  - DATA: byte_ready=1. Shift bytes into a 32-bit assembly register and count bytes 0..3. On the 4th byte, go to CHK if words_loaded+1==N, else stay in DATA.
  - CHK: byte_ready=1. On transfer, go to DONE if byte equals the accumulator, else ERR.
  - DONE: byte_ready=0, done=1, cpu_reset=0.
  - ERR: byte_ready=0, error=1, cpu_reset=1.
  - From DONE or ERR, start restarts exactly as from IDLE (cpu_reset reasserted the next cycle).
- Write timing: the 4th byte of word k is accepted at edge E. In the cycle after E (registered outputs): wea=1, addra=k, dina=assembled word. wea returns to 0 the following cycle unless another word completes.
- words_loaded increments at the same edge that raises wea. addra holds its last value while wea=0.
- Back-to-back bytes are supported (byte_valid high every cycle). Maximum rate is one word per 4 cycles, so no write collision.
- Gaps: byte_valid low stalls state; no timeout.
- The final word's write pulse can coincide with acceptance of CHK; both complete.
- Checksum XOR updates only on transfer, in every receiving state except CHK.
- byte_valid while byte_ready=0 is ignored and does not affect the checksum.
- start is ignored in LEN_HI/LEN_LO/DATA/CHK; a frame cannot be aborted except by reset.
- reset mid-frame: all outputs return to reset values next edge, including any pending wea. Memory contents already written are not undone.
- Address arithmetic: addra = word index, zero-extended to size bits. It wraps only if N > MemSize, which is prevented by ERR.

Test Plan:
- Normal: start; bytes 00 02 | 12 34 56 78 | 9A BC DE F0 | chk=0x02 (XOR of all 10 bytes) -> wea pulses with (addra=0, dina=0x12345678) then (addra=1, dina=0x9ABCDEF0); done=1, cpu_reset=0, words_loaded=2.
- Bad checksum: same frame with chk=0x03 -> both writes occur; error=1, done=0, cpu_reset stays 1.
- Oversize: LEN=0x0201 (513) with MemSize=512 -> ERR right after LEN_LO, no wea pulse, byte_ready=0.
- Zero length: 00 00 then chk=0x00 -> done=1, words_loaded=0, no wea.
- Stalls and back-to-back: the 2-word frame with byte_valid toggling randomly, then repeated with byte_valid held high -> identical writes, one wea pulse per word, 4 cycles apart in the back-to-back case.
- Reset mid-frame: assert reset after the 6th data byte -> next cycle wea=0, addra=0, cpu_reset=1, state IDLE. A fresh start then loads the normal frame correctly.
